// File: rtl/mem_t_secuencia.sv
// Writable pattern table with a one-shot/loop playback sequencer for the actuator output register.
// Optional macro MEM_T_HOLD_EN: a finished one-shot keeps its last entry on salida instead of IDLE_PATTERN.
module mem_t_secuencia #(
  parameter int                 WIDTH        = 11,
  parameter int                 DEPTH        = 4,
  parameter int                 AW           = 2,
  parameter logic [WIDTH-1:0]   IDLE_PATTERN = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW:0]      len,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  output logic [WIDTH-1:0] salida,
  output logic [AW-1:0]    idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  if (DEPTH < 2 || DEPTH > 16 || (2**AW) < DEPTH) begin : g_bad_cfg
    $error("mem_t_secuencia: DEPTH must be 2..16 and fit in AW address bits");
  end

  // Full power-of-two table keeps every idx value in range; entries >= DEPTH are never written.
  logic [WIDTH-1:0] tbl [2**AW];

  state_t           state, state_n;
  logic [AW-1:0]    idx_r, idx_n;
  logic [WIDTH-1:0] sal_r, sal_n;
  logic             done_r, done_n;
  logic [AW:0]      leff, last;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**AW; i++) tbl[i] <= IDLE_PATTERN;
    end else if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    if (len == '0)          leff = LEN_ONE;
    else if (len > DEPTH_W) leff = DEPTH_W;
    else                    leff = len;
    last = leff - LEN_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx_r  <= '0;
      sal_r  <= IDLE_PATTERN;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      idx_r  <= idx_n;
      sal_r  <= sal_n;
      done_r <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx_r;
    done_n  = 1'b0;
`ifdef MEM_T_HOLD_EN
    sal_n   = sal_r;
`else
    sal_n   = IDLE_PATTERN;
`endif
    if (stop) begin
      state_n = IDLE;
      idx_n   = '0;
      sal_n   = IDLE_PATTERN;
    end else if (start) begin
      state_n = RUN;
      idx_n   = '0;
      sal_n   = tbl[0];
    end else if (state == RUN) begin
      if (step) begin
        // ">=" also catches idx stranded past a len that shrank mid-run
        if ({1'b0, idx_r} >= last) begin
          idx_n = '0;
          if (!loop) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else begin
          idx_n = idx_r + IDX_ONE;
        end
      end
      if (state_n == RUN) begin
        sal_n = tbl[idx_n];
      end else begin
`ifdef MEM_T_HOLD_EN
        sal_n = tbl[last[AW-1:0]];
`else
        sal_n = IDLE_PATTERN;
`endif
      end
    end
  end

  assign salida = sal_r;
  assign idx    = idx_r;
  assign busy   = (state == RUN);
  assign done   = done_r;

endmodule

// File: tb/tb_mem_t_secuencia.sv
// Directed vector bench for mem_t_secuencia: DEPTH=4 table-driven run plus a DEPTH=3 boundary sequence.
module tb_mem_t_secuencia;

`ifdef MEM_T_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, wr_en, loop, start, stop, step;
  logic [1:0]  wr_addr, idx;
  logic [10:0] wr_data, salida;
  logic [2:0]  len;
  logic        busy, done;

  logic        b_reset, b_wr_en, b_loop, b_start, b_stop, b_step;
  logic [1:0]  b_wr_addr, b_idx;
  logic [10:0] b_wr_data, b_salida;
  logic [2:0]  b_len;
  logic        b_busy, b_done;

  mem_t_secuencia #(.WIDTH(11), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .loop(loop), .start(start), .stop(stop), .step(step),
    .salida(salida), .idx(idx), .busy(busy), .done(done));

  mem_t_secuencia #(.WIDTH(11), .DEPTH(3), .AW(2)) dut3 (
    .clk(clk), .reset(b_reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .len(b_len), .loop(b_loop), .start(b_start), .stop(b_stop), .step(b_step),
    .salida(b_salida), .idx(b_idx), .busy(b_busy), .done(b_done));

  typedef struct {
    logic        rst, we;
    logic [1:0]  wa;
    logic [10:0] wd;
    logic [2:0]  ln;
    logic        lp, st, sp, sk;
    logic [10:0] es;
    logic [1:0]  ei;
    logic        eb, ed;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic rst, we, input logic [1:0] wa, input logic [10:0] wd,
                     input logic [2:0] ln, input logic lp, st, sp, sk,
                     input logic [10:0] es, input logic [1:0] ei, input logic eb, ed);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.ln = ln; v.lp = lp;
    v.st = st; v.sp = sp; v.sk = sk; v.es = es; v.ei = ei; v.eb = eb; v.ed = ed;
    tv.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [10:0] s, input logic [1:0] i,
                     input logic b, d, input logic [10:0] es, input logic [1:0] ei,
                     input logic eb, ed);
    n_vec++;
    if (s !== es || i !== ei || b !== eb || d !== ed) begin
      n_err++;
      $display("FAIL %s: got salida=%h idx=%0d busy=%b done=%b, want salida=%h idx=%0d busy=%b done=%b",
               tag, s, i, b, d, es, ei, eb, ed);
    end
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0;
    loop = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    b_reset = 1'b1; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_len = '0;
    b_loop = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_step = 1'b0;

    //  rst we wa wd      ln lp st sp sk  salida                   idx busy done
    add(1, 0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h7FF,                  0, 0, 0);  // reset
    add(1, 0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h7FF,                  0, 0, 0);
    add(0, 0, 0, 11'h000, 4, 0, 1, 0, 0, 11'h7FF,                  0, 1, 0);  // table is all ones
    add(0, 0, 0, 11'h000, 4, 0, 0, 0, 1, 11'h7FF,                  1, 1, 0);
    add(0, 0, 0, 11'h000, 4, 0, 0, 0, 1, 11'h7FF,                  2, 1, 0);
    add(0, 0, 0, 11'h000, 4, 0, 0, 0, 1, 11'h7FF,                  3, 1, 0);
    add(0, 0, 0, 11'h000, 4, 0, 0, 1, 0, 11'h7FF,                  0, 0, 0);
    add(0, 1, 0, 11'h741, 0, 0, 0, 0, 0, 11'h7FF,                  0, 0, 0);  // load table
    add(0, 1, 1, 11'h001, 0, 0, 0, 0, 0, 11'h7FF,                  0, 0, 0);
    add(0, 1, 2, 11'h555, 0, 0, 0, 0, 0, 11'h7FF,                  0, 0, 0);
    add(0, 1, 3, 11'h2AA, 0, 0, 0, 0, 0, 11'h7FF,                  0, 0, 0);
    add(0, 0, 0, 11'h000, 3, 0, 1, 0, 0, 11'h741,                  0, 1, 0);  // one-shot len 3
    add(0, 0, 0, 11'h000, 3, 0, 0, 0, 1, 11'h001,                  1, 1, 0);
    add(0, 0, 0, 11'h000, 3, 0, 0, 0, 1, 11'h555,                  2, 1, 0);
    add(0, 0, 0, 11'h000, 3, 0, 0, 0, 1, HOLD ? 11'h555 : 11'h7FF, 0, 0, 1);
    add(0, 0, 0, 11'h000, 3, 0, 0, 0, 0, HOLD ? 11'h555 : 11'h7FF, 0, 0, 0);
    add(0, 0, 0, 11'h000, 3, 0, 0, 1, 0, 11'h7FF,                  0, 0, 0);
    add(0, 0, 0, 11'h000, 2, 1, 1, 0, 0, 11'h741,                  0, 1, 0);  // loop len 2
    add(0, 0, 0, 11'h000, 2, 1, 0, 0, 1, 11'h001,                  1, 1, 0);
    add(0, 0, 0, 11'h000, 2, 1, 0, 0, 1, 11'h741,                  0, 1, 0);
    add(0, 0, 0, 11'h000, 2, 1, 0, 0, 1, 11'h001,                  1, 1, 0);
    add(0, 0, 0, 11'h000, 2, 1, 0, 0, 1, 11'h741,                  0, 1, 0);
    add(0, 0, 0, 11'h000, 2, 1, 0, 0, 1, 11'h001,                  1, 1, 0);
    add(0, 0, 0, 11'h000, 2, 1, 1, 1, 1, 11'h7FF,                  0, 0, 0);  // stop wins
    add(0, 0, 0, 11'h000, 2, 1, 1, 0, 1, 11'h741,                  0, 1, 0);  // start beats step
    add(0, 0, 0, 11'h000, 2, 1, 0, 0, 1, 11'h001,                  1, 1, 0);
    add(0, 0, 0, 11'h000, 2, 1, 1, 0, 0, 11'h741,                  0, 1, 0);  // restart in RUN
    add(0, 0, 0, 11'h000, 0, 1, 0, 0, 1, 11'h741,                  0, 1, 0);  // len 0 -> L=1
    add(0, 0, 0, 11'h000, 0, 1, 0, 0, 1, 11'h741,                  0, 1, 0);
    add(0, 0, 0, 11'h000, 7, 1, 0, 0, 1, 11'h001,                  1, 1, 0);  // len 7 clamps to 4
    add(0, 0, 0, 11'h000, 7, 1, 0, 0, 1, 11'h555,                  2, 1, 0);
    add(0, 0, 0, 11'h000, 7, 1, 0, 0, 1, 11'h2AA,                  3, 1, 0);
    add(0, 0, 0, 11'h000, 7, 1, 0, 0, 1, 11'h741,                  0, 1, 0);
    add(0, 0, 0, 11'h000, 7, 1, 0, 0, 1, 11'h001,                  1, 1, 0);
    add(0, 1, 1, 11'h0F0, 7, 1, 0, 0, 0, 11'h001,                  1, 1, 0);  // write playing entry
    add(0, 0, 0, 11'h000, 7, 1, 0, 0, 0, 11'h0F0,                  1, 1, 0);
    add(0, 0, 0, 11'h000, 1, 0, 0, 0, 1, HOLD ? 11'h741 : 11'h7FF, 0, 0, 1);  // len shrinks
    add(0, 0, 0, 11'h000, 1, 0, 0, 0, 0, HOLD ? 11'h741 : 11'h7FF, 0, 0, 0);
    add(0, 0, 0, 11'h000, 4, 0, 1, 0, 0, 11'h741,                  0, 1, 0);
    add(0, 0, 0, 11'h000, 4, 0, 0, 0, 1, 11'h0F0,                  1, 1, 0);
    add(1, 0, 0, 11'h000, 4, 0, 0, 0, 1, 11'h7FF,                  0, 0, 0);  // reset mid-run
    add(0, 0, 0, 11'h000, 4, 0, 1, 0, 0, 11'h7FF,                  0, 1, 0);  // table re-initialised
    add(0, 0, 0, 11'h000, 4, 0, 0, 0, 1, 11'h7FF,                  1, 1, 0);
    add(0, 0, 0, 11'h000, 4, 0, 0, 1, 0, 11'h7FF,                  0, 0, 0);
    add(0, 0, 0, 11'h000, 4, 0, 0, 0, 1, 11'h7FF,                  0, 0, 0);  // step ignored in IDLE

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst; wr_en = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd;
      len = tv[i].ln; loop = tv[i].lp; start = tv[i].st; stop = tv[i].sp; step = tv[i].sk;
      @(negedge clk);
      chk($sformatf("vec%0d", i), salida, idx, busy, done, tv[i].es, tv[i].ei, tv[i].eb, tv[i].ed);
    end
    reset = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;

    // DEPTH=3: out-of-range write ignored, len 7 clamps to 3 in one-shot
    b_reset = 1'b1;
    @(negedge clk);
    b_reset = 1'b0; b_wr_en = 1'b1; b_wr_addr = 2'd3; b_wr_data = 11'h000;
    @(negedge clk);
    b_wr_addr = 2'd2; b_wr_data = 11'h123;
    @(negedge clk);
    b_wr_en = 1'b0; b_len = 3'd7; b_loop = 1'b0; b_start = 1'b1;
    @(negedge clk);
    chk("d3_start", b_salida, b_idx, b_busy, b_done, 11'h7FF, 2'd0, 1'b1, 1'b0);
    b_start = 1'b0; b_step = 1'b1;
    @(negedge clk);
    chk("d3_step1", b_salida, b_idx, b_busy, b_done, 11'h7FF, 2'd1, 1'b1, 1'b0);
    @(negedge clk);
    chk("d3_step2", b_salida, b_idx, b_busy, b_done, 11'h123, 2'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk("d3_end", b_salida, b_idx, b_busy, b_done, HOLD ? 11'h123 : 11'h7FF, 2'd0, 1'b0, 1'b1);
    b_step = 1'b0;
    @(negedge clk);
    chk("d3_after", b_salida, b_idx, b_busy, b_done, HOLD ? 11'h123 : 11'h7FF, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_t_secuencia.md
Name: mem_t_secuencia

Overview:
- Parametrised, writable pattern memory with a built-in playback sequencer for the fire-fighting machine control.
- Holds DEPTH actuator patterns, each WIDTH bits wide. On command it steps through them one entry per step tick, either once (one-shot) or continuously (loop).
- Replaces fixed per-temperature-band pattern tables. It sits between the temperature/mode controller and the actuator output register.

Parameters:
- WIDTH, 11, bits per pattern word (salida width).
- DEPTH, 4, number of pattern entries (2..16).
- AW, 2, address width; must satisfy 2**AW >= DEPTH.
- IDLE_PATTERN, {WIDTH{1'b1}}, pattern driven when not playing. All ones means all actuators inactive (active-low).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table write address.
- wr_data  in  WIDTH  table write data.
- len  in  AW+1  number of active entries for playback.
- loop  in  1  1 = wrap after the last entry; 0 = one-shot.
- start  in  1  begin playback at entry 0.
- stop  in  1  abort playback.
- step  in  1  advance one entry (one-cycle tick from the timer).
- salida  out  WIDTH  registered pattern output.
- idx  out  AW  current entry index.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at the end of a one-shot.

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE; idx = 0; busy = 0; done = 0; salida = IDLE_PATTERN.
  - All table entries are loaded with IDLE_PATTERN.
  - Reset has priority over every other input, including a reset asserted mid-playback.
- Table write:
  - When wr_en = 1 and wr_addr < DEPTH, entry wr_addr takes wr_data at the clock edge.
  - When wr_addr >= DEPTH, the write is ignored.
  - Writes are accepted in any state.
- Effective length: L = 1 if len = 0; L = DEPTH if len > DEPTH; otherwise L = len.
- States: IDLE, RUN.
- Input priority: reset > stop > start > step.
- IDLE:
  - salida = IDLE_PATTERN; busy = 0; step is ignored.
  - start at edge k: state = RUN, idx = 0, and salida = table[0] after edge k (zero added latency).
- RUN:
  - busy = 1.
  - Every cycle: salida <= table[idx_next], using the table contents before that edge. No write bypass: a write to the playing entry appears at salida one edge later.
  - step with idx < L-1: idx increments.
  - step with idx = L-1 and loop = 1: idx wraps to 0. No done pulse.
  - step with idx = L-1 and loop = 0: state = IDLE, idx = 0, done = 1 for exactly one cycle, salida = IDLE_PATTERN.
  - start while in RUN: restarts at idx 0 without passing through IDLE; no done pulse.
  - stop (any cycle, any state): state = IDLE, idx = 0, salida = IDLE_PATTERN, no done pulse. stop overrides a simultaneous start or step.
  - Changes to len or loop during RUN take effect at the next step. If idx >= the new L at that step, idx goes to 0, or the block ends per loop = 0.
- done is 0 in every other cycle.

Optional Feature:
- Macro: MEM_T_HOLD_EN.
- Defined: at the end of a one-shot, salida keeps the last entry, table[L-1], instead of IDLE_PATTERN. It holds that value through IDLE until the next start, stop, or reset. stop and reset still force IDLE_PATTERN. busy and done behave as without the macro.
- Undefined: behaviour exactly as in Behaviour above.

Test Plan:
- Reset defaults: assert reset for 2 cycles, then start with len=4 and pulse step 3 times -> salida reads 11'h7FF at every step (table reset to all ones); busy=1; idx goes 0,1,2,3.
- One-shot: write entries 11'h741, 11'h001, 11'h555, 11'h2AA; len=3, loop=0; start -> salida 741, 001, 555 on successive steps. The 3rd step gives done=1 for one cycle, busy=0, salida=7FF (with MEM_T_HOLD_EN: salida stays 555).
- Loop: len=2, loop=1, 5 steps -> idx 0,1,0,1,0,1; salida alternates 741/001; done never asserted.
- Priority: same-cycle stop+start+step in RUN -> IDLE, salida=7FF, done=0. Same-cycle start+step in IDLE -> idx=0, salida=741.
- Boundaries: len=0 with loop=1 -> idx stays 0 through steps. len=7 with DEPTH=4 -> wraps after idx 3. wr_addr=3 with AW=2 and DEPTH=3 -> table unchanged.
- Write while playing: in RUN at idx=1, write 11'h0F0 to entry 1 -> salida = 001 at the write edge and 0F0 one edge later.
